// File: rtl/lvds_seq_pkg.sv
// rtl/lvds_seq_pkg.sv - state codes, output bundle and default delays for lvds_pll_sequencer
package lvds_seq_pkg;

    typedef enum logic [3:0] {
        RESET_PLL = 4'h0,
        WAIT_LOCK = 4'h1,
        LOCK_QUAL = 4'h2,
        IDLE      = 4'h3,
        PWR_VDD   = 4'h4,
        PWR_LVDS  = 4'h5,
        RUN       = 4'h6,
        OFF_BL    = 4'h7,
        OFF_LVDS  = 4'h8,
        FAULT     = 4'hF
    } seqState_e;

    localparam int DEF_CNT_W        = 24;
    localparam int DEF_RST_CYCLES   = 16;
    localparam int DEF_LOCK_TIMEOUT = 120000;
    localparam int DEF_LOCK_STABLE  = 1024;
    localparam int DEF_T_VDD        = 600000;
    localparam int DEF_T_BL         = 2400000;
    localparam int DEF_MAX_RETRY    = 3;

    typedef struct packed {
        logic pllRst;
        logic panelVdd;
        logic lvdsEn;
        logic backlightEn;
        logic locked;
        logic panelReady;
        logic fault;
    } seqOut_t;

    // Output levels are a pure function of the state being entered.
    function automatic seqOut_t decodeOutputs(seqState_e s);
        seqOut_t o;
        o = '0;
        case (s)
            RESET_PLL: o.pllRst = 1'b1;
            IDLE:      o.locked = 1'b1;
            PWR_VDD, OFF_LVDS: begin
                o.locked   = 1'b1;
                o.panelVdd = 1'b1;
            end
            PWR_LVDS, OFF_BL: begin
                o.locked   = 1'b1;
                o.panelVdd = 1'b1;
                o.lvdsEn   = 1'b1;
            end
            RUN: begin
                o.locked      = 1'b1;
                o.panelVdd    = 1'b1;
                o.lvdsEn      = 1'b1;
                o.backlightEn = 1'b1;
                o.panelReady  = 1'b1;
            end
            FAULT: begin
                o.fault  = 1'b1;
                o.pllRst = 1'b1;
            end
            default: ;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/lvds_pll_sequencer_lock_sync.sv
// rtl/lvds_pll_sequencer_lock_sync.sv - two-flop synchronizer for the asynchronous PLL lock
module lock_sync (
    input  logic clk,
    input  logic rstN,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/lvds_pll_sequencer.sv
// rtl/lvds_pll_sequencer.sv - PLL reset/lock qualification and LCD panel power sequencing
// Optional LVDS_SEQ_DEBUG_EN adds seqState and lockLossCnt observation ports.
module lvds_pll_sequencer
    import lvds_seq_pkg::*;
#(
    parameter int CNT_W        = DEF_CNT_W,
    parameter int RST_CYCLES   = DEF_RST_CYCLES,
    parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
    parameter int LOCK_STABLE  = DEF_LOCK_STABLE,
    parameter int T_VDD        = DEF_T_VDD,
    parameter int T_BL         = DEF_T_BL,
    parameter int MAX_RETRY    = DEF_MAX_RETRY
) (
    input  logic       clk,
    input  logic       rstN,
    input  logic       pllLock,
    input  logic       panelEn,
    output logic       pllRst,
    output logic       panelVdd,
    output logic       lvdsEn,
    output logic       backlightEn,
    output logic       locked,
    output logic       panelReady,
    output logic       fault
`ifdef LVDS_SEQ_DEBUG_EN
    ,
    output logic [3:0] seqState,
    output logic [7:0] lockLossCnt
`endif
);

    localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0]   VDD_LAST     = CNT_W'(T_VDD - 1);
    localparam logic [CNT_W-1:0]   BL_LAST      = CNT_W'(T_BL - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRY);

    seqState_e          state, nextState;
    logic [CNT_W-1:0]   cnt, nextCnt;
    logic [RETRY_W-1:0] retry, nextRetry;
    logic               lockSync, lockLost, cntClr, cntHold;
    seqOut_t            outs;

    lock_sync uLockSync (
        .clk  (clk),
        .rstN (rstN),
        .d    (pllLock),
        .q    (lockSync)
    );

    assign lockLost = !lockSync &&
                      (state inside {IDLE, PWR_VDD, PWR_LVDS, RUN, OFF_BL, OFF_LVDS});

    always_comb begin
        nextState = state;
        nextRetry = retry;
        cntClr    = 1'b0;
        cntHold   = 1'b0;
        // Lock loss outranks panelEn and timer expiry in any panel state.
        if (lockLost) begin
            nextState = RESET_PLL;
            nextRetry = '0;
        end else begin
            case (state)
                RESET_PLL: if (cnt == RST_LAST) nextState = WAIT_LOCK;
                WAIT_LOCK: begin
                    if (lockSync) begin
                        nextState = LOCK_QUAL;
                    end else if (cnt == TIMEOUT_LAST) begin
                        if (retry < RETRY_MAX) begin
                            nextRetry = retry + 1'b1;
                            nextState = RESET_PLL;
                        end else begin
                            nextState = FAULT;
                        end
                    end
                end
                LOCK_QUAL: begin
                    if (!lockSync)               cntClr    = 1'b1;
                    else if (cnt == STABLE_LAST) nextState = IDLE;
                end
                IDLE: begin
                    cntHold   = 1'b1;
                    nextRetry = '0;
                    if (panelEn) nextState = PWR_VDD;
                end
                PWR_VDD: begin
                    if (!panelEn)             nextState = OFF_LVDS;
                    else if (cnt == VDD_LAST) nextState = PWR_LVDS;
                end
                PWR_LVDS: begin
                    if (!panelEn)            nextState = OFF_BL;
                    else if (cnt == BL_LAST) nextState = RUN;
                end
                RUN: begin
                    cntHold = 1'b1;
                    if (!panelEn) nextState = OFF_BL;
                end
                OFF_BL:   if (cnt == BL_LAST)  nextState = OFF_LVDS;
                OFF_LVDS: if (cnt == VDD_LAST) nextState = IDLE;
                FAULT: begin
                    cntHold = 1'b1;
                    if (!panelEn) begin
                        nextState = RESET_PLL;
                        nextRetry = '0;
                    end
                end
                default: nextState = RESET_PLL;
            endcase
        end

        if (nextState != state || cntClr) nextCnt = '0;
        else if (cntHold)                 nextCnt = cnt;
        else                              nextCnt = cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state <= RESET_PLL;
            cnt   <= '0;
            retry <= '0;
            outs  <= decodeOutputs(RESET_PLL);
        end else begin
            state <= nextState;
            cnt   <= nextCnt;
            retry <= nextRetry;
            outs  <= decodeOutputs(nextState);
        end
    end

    assign pllRst      = outs.pllRst;
    assign panelVdd    = outs.panelVdd;
    assign lvdsEn      = outs.lvdsEn;
    assign backlightEn = outs.backlightEn;
    assign locked      = outs.locked;
    assign panelReady  = outs.panelReady;
    assign fault       = outs.fault;

`ifdef LVDS_SEQ_DEBUG_EN
    logic [7:0] lossCnt;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN)                           lossCnt <= '0;
        else if (lockLost && lossCnt != '1)  lossCnt <= lossCnt + 1'b1;
    end

    assign seqState    = state;
    assign lockLossCnt = lossCnt;
`endif

endmodule
